wbtarget: RTL and testbench
===========================

# wbtarget

Parametrised Wishbone target model with programmable latency, for the chad/spif benches and small FPGA builds. It replaces the one-register, fixed one-cycle loopback behind the spif Wishbone master with a DEPTH-word memory and a per-transaction wait-state count. It adds optional pseudo-random latency jitter, an error response for out-of-range addresses, and transaction counters. It is synthesizable and sits directly on the spif `adr_o/dat_o/dat_i/we_o/stb_o/ack_i` pins.

## Interface
- AW, 15, address width (matches spif `adr_o`)
- DW, 32, data width
- DEPTH, 1024, words implemented; legal addresses are 0..DEPTH-1 (need not be a power of 2)
- RANDOM, 0, 1 = add LFSR jitter of 0..3 cycles to each wait
- CW, 16, counter width
- clk  in  1  system clock; one clock, all logic on its rising edge
- arstn  in  1  reset, asynchronous, active-low
- adr_i  in  AW  word address
- dat_i  in  DW  write data
- we_i  in  1  1 = write, 0 = read
- stb_i  in  1  strobe; held by the master until ack_o or err_o
- wait_i  in  4  wait states, sampled at accept
- dat_o  out  DW  read data, valid while ack_o=1
- ack_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle error pulse for address >= DEPTH
- busy  out  1  high in WAIT, ACK or ERR
- rd_cnt, wr_cnt, err_cnt  out  CW each  completed reads, writes and errors; wrap modulo 2^CW

## Operation
- FSM states: IDLE, WAIT, ACK, ERR.
- IDLE with stb_i=1 at an edge: accept the transaction.
  - Latch adr_i, dat_i and we_i.
  - Load wcnt = wait_i + (RANDOM ? lfsr[1:0] : 0), 6-bit, no overflow.
  - Step the LFSR once per accept.
  - Next state: WAIT if wcnt≠0. Otherwise ACK, or ERR if the latched address is >= DEPTH.
- WAIT: decrement wcnt each cycle. At wcnt==1, go to ACK (or ERR).
- ACK, in-range address:
  - ack_o=1 for exactly one cycle.
  - Write: mem[adr] is updated at the edge entering ACK; wr_cnt++.
  - Read: dat_o = mem[adr], registered at the edge entering ACK; rd_cnt++.
  - Next state: IDLE.
- ERR: err_o=1 for one cycle, memory untouched, dat_o=0, err_cnt++. Next state: IDLE.
- Abort: stb_i=0 during WAIT returns to IDLE at that edge. No write, no pulse, no count.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 at reset. Present but frozen when RANDOM=0.
- Memory array has no reset. Contents survive arstn. Bench must write before reading.

## Timing
- Reset values:
  - state = IDLE
  - ack_o = err_o = busy = 0
  - dat_o = 0
  - all counters = 0
  - lfsr = 16'hACE1
- Latency: stb_i seen high at edge k, ack_o/err_o high during cycle k+1+wcnt and low again after it.
  - wait_i=0 with RANDOM=0 reproduces the previous loopback stub exactly: ack one cycle after stb.
- ack_o and err_o are mutually exclusive. Neither is asserted for more than one cycle per transaction.
- Back-to-back transactions:
  - IDLE re-samples stb_i the edge after ACK/ERR.
  - A master that holds stb_i high starts a new transaction there, with one idle cycle between pulses.
  - A master that drops stb_i after seeing ack_o gets no duplicate transaction.
- adr_i, dat_i and we_i changes after accept are ignored.
- arstn asserted mid-WAIT or mid-ACK:
  - Immediate return to IDLE with outputs at their reset values.
  - A write whose edge has not yet occurred is lost.

## Test plan
- Reset, then write 32'hDEADBEEF to address 5, wait_i=0 → ack_o in the cycle after stb_i, wr_cnt=1. Then read address 5 → dat_o=32'hDEADBEEF with ack_o, rd_cnt=1.
- wait_i=7, read address 0 → ack_o exactly 8 cycles after the stb_i edge, busy high for 8 cycles.
- DEPTH=1000, write to address 1000 → err_o for one cycle, ack_o stays 0, err_cnt=1. Then read address 1000 → dat_o=0.
- Abort: wait_i=5, write 32'h1234 to address 3, drop stb_i after 2 cycles → no ack_o, wr_cnt unchanged, mem[3] keeps its previous value.
- RANDOM=1, wait_i=2, 64 reads → every latency in 3..6 cycles. Reset and repeat → identical latency sequence.
- CW=4, 17 writes → wr_cnt=1. Pulse arstn during a WAIT → all outputs zero, next transaction behaves normally.

Source files
------------

// File: rtl/wbtarget.sv
// wbtarget: Wishbone target model with a DEPTH-word memory and a
// per-transaction wait-state count. Pseudo-random jitter (0..3 cycles) can be
// added to each wait. Addresses at or above DEPTH are answered with err_o.
// All responses are registered.
//
// Ports:
//   clk      system clock, all logic on its rising edge
//   arstn    asynchronous active-low reset
//   adr_i    word address            dat_i   write data
//   we_i     1 = write, 0 = read     stb_i   strobe, held until ack_o/err_o
//   wait_i   wait states, sampled when the transaction is accepted
//   dat_o    read data, valid with ack_o (0 after an error)
//   ack_o    one-cycle completion pulse
//   err_o    one-cycle error pulse for out-of-range addresses
//   busy     high while in WAIT, ACK or ERR
//   rd_cnt, wr_cnt, err_cnt   completed reads, writes and errors (wrapping)
module wbtarget #(
  parameter int AW     = 15,
  parameter int DW     = 32,
  parameter int DEPTH  = 1024,
  parameter int RANDOM = 0,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          arstn,
  input  logic [AW-1:0] adr_i,
  input  logic [DW-1:0] dat_i,
  input  logic          we_i,
  input  logic          stb_i,
  input  logic [3:0]    wait_i,
  output logic [DW-1:0] dat_o,
  output logic          ack_o,
  output logic          err_o,
  output logic          busy,
  output logic [CW-1:0] rd_cnt,
  output logic [CW-1:0] wr_cnt,
  output logic [CW-1:0] err_cnt
);

  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} state_t;

  state_t        state;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] dat_q;
  logic          we_q;
  logic [5:0]    wcnt;
  logic [15:0]   lfsr;

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] adr_e;
  logic [DW-1:0] dat_e;
  logic          we_e;
  logic [1:0]    jitter;
  logic [5:0]    wload;
  logic          accept;
  logic          finish;
  logic          in_range;
  logic          lfsr_fb;

  // The effective transaction comes straight from the bus on a zero-wait
  // accept and from the latched copy once we are waiting, so that a write
  // always lands on the edge that enters ACK.
  always_comb begin
    jitter   = (RANDOM != 0) ? lfsr[1:0] : 2'd0;
    wload    = 6'(wait_i) + 6'(jitter);
    accept   = (state == IDLE) && stb_i;
    adr_e    = accept ? adr_i : adr_q;
    dat_e    = accept ? dat_i : dat_q;
    we_e     = accept ? we_i  : we_q;
    in_range = {1'b0, adr_e} < DEPTH_L;
    finish   = (accept && (wload == 6'd0)) ||
               ((state == WAIT) && stb_i && (wcnt == 6'd1));
  end

  // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state   <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      wcnt    <= '0;
      lfsr    <= 16'hACE1;
      dat_o   <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      busy    <= 1'b0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      if (accept) begin
        adr_q <= adr_i;
        dat_q <= dat_i;
        we_q  <= we_i;
        wcnt  <= wload;
        if (RANDOM != 0) lfsr <= {lfsr_fb, lfsr[15:1]};
      end
      if (finish) begin
        busy <= 1'b1;
        if (in_range) begin
          state <= ACK;
          ack_o <= 1'b1;
          if (we_e) begin
            wr_cnt <= wr_cnt + CW'(1);
          end else begin
            rd_cnt <= rd_cnt + CW'(1);
            dat_o  <= mem[adr_e[IW-1:0]];
          end
        end else begin
          state   <= ERR;
          err_o   <= 1'b1;
          err_cnt <= err_cnt + CW'(1);
          dat_o   <= '0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              state <= WAIT;
              busy  <= 1'b1;
            end
          end
          WAIT: begin
            // master gave up: drop the transaction silently
            if (!stb_i) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              wcnt <= wcnt - 6'd1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Memory has no reset so contents survive arstn; writes are blocked while
  // reset is held because the FSM may look like it is accepting.
  always_ff @(posedge clk) begin
    if (arstn && finish && in_range && we_e) mem[adr_e[IW-1:0]] <= dat_e;
  end

endmodule

// File: tb/tb_wbtarget.sv
module tb_wbtarget;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic [14:0] adr = '0;
  logic [31:0] dat = '0;
  logic        we = 1'b0;
  logic [3:0]  wt = '0;
  logic        stb0 = 1'b0, stb1 = 1'b0;

  logic [31:0] do0, do1;
  logic        ack0, ack1, err0, err1, busy0, busy1;
  logic [3:0]  rc0, wc0, ec0;
  logic [15:0] rc1, wc1, ec1;

  int cur = 0;
  logic        s_ack, s_err, s_busy;
  logic [31:0] s_do;
  logic [15:0] s_rc, s_wc, s_ec;

  assign s_ack  = cur != 0 ? ack1  : ack0;
  assign s_err  = cur != 0 ? err1  : err0;
  assign s_busy = cur != 0 ? busy1 : busy0;
  assign s_do   = cur != 0 ? do1   : do0;
  assign s_rc   = cur != 0 ? rc1 : {12'd0, rc0};
  assign s_wc   = cur != 0 ? wc1 : {12'd0, wc0};
  assign s_ec   = cur != 0 ? ec1 : {12'd0, ec0};

  wbtarget #(.AW(15), .DW(32), .DEPTH(1000), .RANDOM(0), .CW(4)) u_dut0 (
    .clk(clk), .arstn(arstn), .adr_i(adr), .dat_i(dat), .we_i(we),
    .stb_i(stb0), .wait_i(wt), .dat_o(do0), .ack_o(ack0), .err_o(err0),
    .busy(busy0), .rd_cnt(rc0), .wr_cnt(wc0), .err_cnt(ec0));

  wbtarget #(.AW(15), .DW(32), .DEPTH(1000), .RANDOM(1), .CW(16)) u_dut1 (
    .clk(clk), .arstn(arstn), .adr_i(adr), .dat_i(dat), .we_i(we),
    .stb_i(stb1), .wait_i(wt), .dat_o(do1), .ack_o(ack1), .err_o(err1),
    .busy(busy1), .rd_cnt(rc1), .wr_cnt(wc1), .err_cnt(ec1));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: memory image, counters and jitter source per instance
  logic [31:0] mm [2][1000];
  bit          mv [2][1000];
  int          rdc [2];
  int          wrc [2];
  int          erc [2];
  logic [15:0] lf;
  int          last_lat;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    int b;
    b = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return 16'((int'(v) >> 1) | (b << 15));
  endfunction

  function automatic logic [15:0] cmask(input int r);
    return r != 0 ? 16'hFFFF : 16'h000F;
  endfunction

  task automatic chk_counters(input int r);
    chk("rd_cnt",  s_rc, 16'(rdc[r]) & cmask(r));
    chk("wr_cnt",  s_wc, 16'(wrc[r]) & cmask(r));
    chk("err_cnt", s_ec, 16'(erc[r]) & cmask(r));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ack0", {ack0, err0, busy0}, 0);
    chk("rst_ack1", {ack1, err1, busy1}, 0);
    chk("rst_dat0", do0, 0);
    chk("rst_dat1", do1, 0);
    chk("rst_cnt0", {rc0, wc0, ec0}, 0);
    chk("rst_cnt1", {rc1, wc1, ec1}, 0);
  endtask

  // called #1 after a rising edge; leaves the bench #1 after a later edge
  task automatic pulse_rst();
    stb0 = 1'b0;
    stb1 = 1'b0;
    arstn = 1'b0;
    #2;
    chk_reset_outputs();
    for (int i = 0; i < 2; i++) begin
      rdc[i] = 0; wrc[i] = 0; erc[i] = 0;
    end
    lf = 16'hACE1;
    @(posedge clk);
    @(negedge clk);
    arstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input int r, input bit w, input int a, input logic [31:0] d, input int wv);
    int   expl, n, nb;
    bit   done, sa, se, exp_err;
    logic [31:0] gd;
    cur = r;
    exp_err = (a >= 1000);
    expl = 1 + wv + (r != 0 ? int'(lf[1:0]) : 0);
    if (r != 0) lf = lfsr_next(lf);
    adr = 15'(a); dat = d; we = w; wt = 4'(wv);
    if (r != 0) stb1 = 1'b1; else stb0 = 1'b1;
    n = 0; nb = 0; done = 0; sa = 0; se = 0; gd = '0;
    while (n < 40 && !done) begin
      @(posedge clk);
      #1;
      n++;
      if (s_busy) nb++;
      if (s_ack || s_err) begin
        done = 1; sa = s_ack; se = s_err; gd = s_do;
      end
    end
    stb0 = 1'b0;
    stb1 = 1'b0;
    last_lat = n;
    chk("latency", n, expl);
    chk("busy_cycles", nb, expl);
    chk("ack", sa, !exp_err);
    chk("err", se, exp_err);
    if (exp_err) begin
      erc[r]++;
      chk("err_dat", gd, 0);
    end else if (w) begin
      wrc[r]++;
      mm[r][a] = d;
      mv[r][a] = 1;
    end else begin
      rdc[r]++;
      if (mv[r][a]) chk("rd_dat", gd, mm[r][a]);
    end
    @(posedge clk);
    #1;
    chk("single_pulse", {s_ack, s_err}, 0);
    chk("idle_busy", s_busy, 0);
    chk_counters(r);
  endtask

  logic [7:0] lat_a [64];
  int wr_before;
  int pulses;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    lf = 16'hACE1;
    #3;
    chk_reset_outputs();
    @(negedge clk);
    arstn = 1'b1;
    @(posedge clk);
    #1;

    // basic write / read, zero wait
    txn(0, 1, 5, 32'hDEADBEEF, 0);
    chk("first_wr_cnt", wc0, 4'd1);
    txn(0, 0, 5, 32'h0, 0);
    chk("first_rd_dat", do0, 32'hDEADBEEF);

    // long wait
    txn(0, 1, 0, 32'hCAFE0000, 3);
    txn(0, 0, 0, 32'h0, 7);
    chk("wait7_latency", last_lat, 8);

    // address boundary
    txn(0, 1, 999, 32'h99999999, 0);
    txn(0, 0, 999, 32'h0, 2);
    txn(0, 1, 1000, 32'h11111111, 0);
    txn(0, 0, 1000, 32'h0, 0);
    txn(0, 0, 1000, 32'h0, 4);

    // abort during WAIT
    txn(0, 1, 3, 32'h55AA55AA, 0);
    cur = 0;
    wr_before = wrc[0];
    adr = 15'd3; dat = 32'h1234; we = 1'b1; wt = 4'd5; stb0 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    stb0 = 1'b0;
    pulses = 0;
    @(posedge clk); #1;
    chk("abort_busy", busy0, 0);
    for (int i = 0; i < 10; i++) begin
      if (ack0 || err0) pulses++;
      @(posedge clk); #1;
    end
    chk("abort_pulses", pulses, 0);
    chk("abort_wr_cnt", wc0, 4'(wr_before));
    txn(0, 0, 3, 32'h0, 0);

    // held strobe: new transaction each other cycle
    cur = 0;
    adr = 15'd5; we = 1'b0; wt = 4'd0; stb0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("b2b_ack", ack0, (i % 2) == 0);
      if (ack0) chk("b2b_dat", do0, mm[0][5]);
    end
    stb0 = 1'b0;
    rdc[0] += 3;
    @(posedge clk); #1;
    chk_counters(0);

    // randomized traffic on the fixed-latency instance
    for (int i = 0; i < 24; i++)
      txn(0, 1'($urandom_range(1, 0)), $urandom_range(1010, 0), $urandom, $urandom_range(15, 0));

    // counter wrap
    wr_before = wrc[0];
    for (int i = 0; i < 17; i++)
      txn(0, 1, $urandom_range(999, 0), $urandom, 0);
    chk("wrap_wr_cnt", wc0, 4'(wr_before + 1));

    // reset during WAIT loses the pending write
    txn(0, 1, 7, 32'hA0A0A0A0, 0);
    cur = 0;
    adr = 15'd7; dat = 32'hBADBAD00; we = 1'b1; wt = 4'd9; stb0 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    pulse_rst();
    txn(0, 0, 7, 32'h0, 1);
    txn(0, 1, 8, 32'h12345678, 2);
    txn(0, 0, 8, 32'h0, 0);

    // jitter: repeatable sequence after reset
    for (int i = 0; i < 8; i++) txn(1, 1, i, $urandom, $urandom_range(3, 0));
    pulse_rst();
    for (int i = 0; i < 64; i++) begin
      txn(1, 0, i % 8, 32'h0, 2);
      lat_a[i] = 8'(last_lat);
      chk("jitter_range", (last_lat >= 3) && (last_lat <= 6), 1);
    end
    pulse_rst();
    for (int i = 0; i < 64; i++) begin
      txn(1, 0, i % 8, 32'h0, 2);
      chk("jitter_repeat", last_lat, lat_a[i]);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
